vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Upstream display stage: produces 640x480@60 VGA timing from the 100 MHz system clock.
//  Drives hSync/vSync to the connector and supplies hCount, vCount and bright to the sprite and game blocks.
//  Those blocks draw when bright=1 and their rgb goes to the pins.
//  Also emits line/frame strobes so game logic updates positions and score once per frame, during blanking.
// PARAMETERS
//  CLK_DIV   4    sys clocks per pixel (100 MHz -> 25 MHz pixel enable); legal >=2
//  H_SYNC    96   hsync pulse width, pixels
//  H_BP      48   horizontal back porch, pixels
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch, pixels
//  V_SYNC    2    vsync pulse width, lines
//  V_BP      33   vertical back porch, lines
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch, lines
// PORTS
//  clk         in   1   system clock, 100 MHz
//  rst         in   1   one clock; reset is synchronous and active-high
//  pix_en      out  1   1-clk strobe, once every CLK_DIV clocks; counters advance on it
//  hCount      out  10  0..H_TOTAL-1 (799); sync pulse starts at 0
//  vCount      out  10  0..V_TOTAL-1 (524); sync pulse starts at 0
//  hSync       out  1   active-low; 0 while hCount < H_SYNC
//  vSync       out  1   active-low; 0 while vCount < V_SYNC
//  bright      out  1   1 while hCount in 144..783 and vCount in 35..514 (defaults)
//  line_tick   out  1   1-clk pulse on the clock hCount wraps to 0
//  frame_tick  out  1   1-clk pulse on entry to vCount=515, hCount=0 (start of vertical front porch)
//  frame_cnt   out  16  frames completed since reset, wraps 65535->0
// BEHAVIOUR
//  - H_TOTAL=H_SYNC+H_BP+H_ACTIVE+H_FP=800; V_TOTAL=525.
//  - Active window: H_SYNC+H_BP .. H_TOTAL-H_FP-1; same rule vertically.
//  - Reset (sync, rst=1 at posedge): div=0, hCount=0, vCount=0, hSync=0, vSync=0, bright=0.
//    pix_en, line_tick, frame_tick and frame_cnt are all 0 on reset.
//  - Reset has priority over every other event. Mid-frame reset: reset values on the next edge; no partial tick is emitted.
//  - Divider: div counts 0..CLK_DIV-1 and wraps. pix_en=1 for the one clock where div==CLK_DIV-1.
//    After rst falls, the first pix_en occurs CLK_DIV clocks later.
//  - On pix_en: hCount increments. At hCount==H_TOTAL-1 it wraps to 0 and vCount advances.
//    At vCount==V_TOTAL-1 vCount also wraps to 0.
//  - hSync, vSync and bright are registered from the next counter values.
//    They therefore change on the same edge as hCount/vCount, with zero skew.
//  - line_tick and frame_tick are registered together with the counters and are high only the clock after the update.
//    They are never high without pix_en on the same update edge.
//  - frame_cnt increments on the same edge that frame_tick rises.
//  - No handshake: consumers sample on pix_en, or on any clock (outputs hold between pix_en strobes).
// CONFIGURATION
//  VGA_TEST_PATTERN_EN defined:
//   - Adds output rgb_tp[11:0]: 8 vertical colour bars, each H_ACTIVE/8 (80) px wide.
//   - Bar order: white, yellow, cyan, green, magenta, red, blue, black (12'hFFF,FF0,0FF,0F0,F0F,F00,00F,000).
//   - rgb_tp is 12'h000 whenever bright=0, registered aligned with bright; reset value 0.
//   - Used for monitor bring-up without the game blocks.
//  VGA_TEST_PATTERN_EN undefined: the rgb_tp port and its logic are absent. All other behaviour is identical.
// STRUCTURE
//  - Package vga_timing_pkg holds the default timing constants, H_TOTAL/V_TOTAL, HACT_START/VACT_START, and the test-pattern colour table.
//  - Sub-module vga_pix_en_gen: CLK_DIV divider with sync reset, output pix_en.
//  - Counters, sync/bright decode and tick logic stay in the top module.
// TESTING
//  1 Hold rst 3 clks, then release -> all outputs are reset values while rst=1; first pix_en on the 4th clk after release.
//  2 Run 800 pix_en -> hCount back to 0, line_tick exactly once; hSync low for 96 pix_en (384 clk).
//  3 Run a full frame -> 420000 pix_en; bright high for exactly 307200 pix_en.
//    bright first high at (144,35), last at (783,514).
//  4 Run two frames -> frame_tick once per frame at vCount=515/hCount=0.
//    frame_cnt 0->1->2; vSync low for exactly 2 lines (1600 pix_en).
//  5 Assert rst at hCount=500, vCount=200 -> next clk hCount=vCount=0, hSync=vSync=0; no tick pulses.
//  6 With VGA_TEST_PATTERN_EN: (hCount=144,vCount=35) -> rgb_tp=FFF; (224,35) -> FF0;
//    (783,35) -> 000; (100,35) -> 000.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing constants, derived totals and
// active-window starts, plus the test-pattern colour bar table.
package vga_timing_pkg;

  localparam int unsigned CLK_DIV_DEF  = 4;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;

  localparam int unsigned H_TOTAL    = H_SYNC_DEF + H_BP_DEF + H_ACTIVE_DEF + H_FP_DEF;
  localparam int unsigned V_TOTAL    = V_SYNC_DEF + V_BP_DEF + V_ACTIVE_DEF + V_FP_DEF;
  localparam int unsigned HACT_START = H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned VACT_START = V_SYNC_DEF + V_BP_DEF;

  localparam int unsigned TP_BARS = 8;

  // Bar 0 is leftmost: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [11:0] tp_colour(input logic [2:0] bar);
    logic [11:0] c;
    case (bar)
      3'd0:    c = 12'hFFF;
      3'd1:    c = 12'hFF0;
      3'd2:    c = 12'h0FF;
      3'd3:    c = 12'h0F0;
      3'd4:    c = 12'hF0F;
      3'd5:    c = 12'hF00;
      3'd6:    c = 12'h00F;
      default: c = 12'h000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_pix_en_gen.sv
// vga_pix_en_gen: divides the system clock by CLK_DIV into a one-clock
// pixel-enable strobe. Synchronous active-high reset.
// Ports:
//   clk    in   system clock
//   rst    in   synchronous reset, active high
//   pix_en out  high for one clock every CLK_DIV clocks
module vga_pix_en_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en
);

  localparam int unsigned     DW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0]   DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          pix_en_q, pix_en_d;

  // pix_en is registered from the next divider value, so it is high exactly
  // while div_q == CLK_DIV-1.
  always_comb begin
    div_d    = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    pix_en_d = (div_d == DIV_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= '0;
      pix_en_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      pix_en_q <= pix_en_d;
    end
  end

  assign pix_en = pix_en_q;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing (640x480@60 by default) from the system
// clock. Counters, sync/bright decode and line/frame strobes live here; the
// pixel-enable divider is vga_pix_en_gen.
// Optional feature macro: VGA_TEST_PATTERN_EN adds rgb_tp (8 colour bars).
// Ports:
//   clk        in   system clock
//   rst        in   synchronous reset, active high
//   pix_en     out  pixel-enable strobe; counters advance on it
//   hCount     out  horizontal position 0..H_TOTAL-1
//   vCount     out  vertical position 0..V_TOTAL-1
//   hSync      out  active-low horizontal sync
//   vSync      out  active-low vertical sync
//   bright     out  high inside the visible window
//   line_tick  out  one-clock pulse after hCount wraps to 0
//   frame_tick out  one-clock pulse on entry to the vertical front porch
//   frame_cnt  out  frames completed since reset (wraps)
//   rgb_tp     out  test-pattern colour (only with VGA_TEST_PATTERN_EN)
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV  = CLK_DIV_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic        pix_en,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        hSync,
  output logic        vSync,
  output logic        bright,
  output logic        line_tick,
  output logic        frame_tick,
  output logic [15:0] frame_cnt
`ifdef VGA_TEST_PATTERN_EN
  ,
  output logic [11:0] rgb_tp
`endif
);

  localparam int unsigned HT = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned VT = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [9:0] H_LAST    = 10'(HT - 1);
  localparam logic [9:0] V_LAST    = 10'(VT - 1);
  localparam logic [9:0] H_SYNC_W  = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_W  = 10'(V_SYNC);
  localparam logic [9:0] HACT_S    = 10'(H_SYNC + H_BP);
  localparam logic [9:0] HACT_E    = 10'(HT - H_FP - 1);
  localparam logic [9:0] VACT_S    = 10'(V_SYNC + V_BP);
  localparam logic [9:0] VACT_E    = 10'(VT - V_FP - 1);
  localparam logic [9:0] VFP_START = 10'(VT - V_FP);

  logic [9:0]  hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        bright_q, bright_d;
  logic        line_tick_q, line_tick_d;
  logic        frame_tick_q, frame_tick_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  vga_pix_en_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_pix_en (
    .clk   (clk),
    .rst   (rst),
    .pix_en(pix_en)
  );

  // Sync, bright and strobes are decoded from the next counter values so
  // they land on the same edge as hCount/vCount.
  always_comb begin
    hcnt_d       = hcnt_q;
    vcnt_d       = vcnt_q;
    hsync_d      = hsync_q;
    vsync_d      = vsync_q;
    bright_d     = bright_q;
    line_tick_d  = 1'b0;
    frame_tick_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;

    if (pix_en) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d      = '0;
        line_tick_d = 1'b1;
        vcnt_d      = (vcnt_q == V_LAST) ? '0 : vcnt_q + 10'd1;
      end else begin
        hcnt_d = hcnt_q + 10'd1;
      end

      hsync_d  = (hcnt_d >= H_SYNC_W);
      vsync_d  = (vcnt_d >= V_SYNC_W);
      bright_d = (hcnt_d >= HACT_S) && (hcnt_d <= HACT_E) &&
                 (vcnt_d >= VACT_S) && (vcnt_d <= VACT_E);

      // hcnt_d is only 0 here on a line wrap.
      frame_tick_d = line_tick_d && (vcnt_d == VFP_START);
      if (frame_tick_d) begin
        frame_cnt_d = frame_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      bright_q     <= 1'b0;
      line_tick_q  <= 1'b0;
      frame_tick_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      bright_q     <= bright_d;
      line_tick_q  <= line_tick_d;
      frame_tick_q <= frame_tick_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign hCount     = hcnt_q;
  assign vCount     = vcnt_q;
  assign hSync      = hsync_q;
  assign vSync      = vsync_q;
  assign bright     = bright_q;
  assign line_tick  = line_tick_q;
  assign frame_tick = frame_tick_q;
  assign frame_cnt  = frame_cnt_q;

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned BAR_W = H_ACTIVE / TP_BARS;

  logic [11:0] rgb_q, rgb_d;
  logic [9:0]  hoff;
  logic [2:0]  bar;

  // Bar index by threshold compare instead of a divide by BAR_W.
  always_comb begin
    rgb_d = rgb_q;
    hoff  = hcnt_d - HACT_S;
    bar   = '0;
    for (int unsigned i = 1; i < TP_BARS; i++) begin
      if (hoff >= 10'(i * BAR_W)) begin
        bar = 3'(i);
      end
    end
    if (pix_en) begin
      rgb_d = bright_d ? tp_colour(bar) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign rgb_tp = rgb_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen using a reduced raster (25 x 13) so full
// frames stay short. Expected values are hand-computed for that raster.
module tb_vga_timing_gen;

  localparam int unsigned CD  = 4;
  localparam int unsigned HSY = 4;
  localparam int unsigned HBP = 3;
  localparam int unsigned HAC = 16;
  localparam int unsigned HFP = 2;
  localparam int unsigned VSY = 2;
  localparam int unsigned VBP = 3;
  localparam int unsigned VAC = 6;
  localparam int unsigned VFP = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_en;
  logic [9:0]  hCount;
  logic [9:0]  vCount;
  logic        hSync;
  logic        vSync;
  logic        bright;
  logic        line_tick;
  logic        frame_tick;
  logic [15:0] frame_cnt;
  logic [11:0] rgb_tp;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV (CD),
    .H_SYNC  (HSY),
    .H_BP    (HBP),
    .H_ACTIVE(HAC),
    .H_FP    (HFP),
    .V_SYNC  (VSY),
    .V_BP    (VBP),
    .V_ACTIVE(VAC),
    .V_FP    (VFP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pix_en    (pix_en),
    .hCount    (hCount),
    .vCount    (vCount),
    .hSync     (hSync),
    .vSync     (vSync),
    .bright    (bright),
    .line_tick (line_tick),
    .frame_tick(frame_tick),
    .frame_cnt (frame_cnt)
`ifdef VGA_TEST_PATTERN_EN
    ,
    .rgb_tp    (rgb_tp)
`endif
  );

`ifndef VGA_TEST_PATTERN_EN
  assign rgb_tp = '0;
`endif

  typedef struct {
    int unsigned p;      // pixel updates since reset
    int unsigned h;
    int unsigned v;
    logic [2:0]  flags;  // {hSync, vSync, bright}
    logic [15:0] fc;
    logic [11:0] rgb;
  } vec_t;

  vec_t tbl[15];

  int          checks = 0;
  int          errors = 0;
  int unsigned pc = 0;
  int          stale = 0;
  int          lt_cnt = 0, ft_cnt = 0, br_cnt = 0, hs_lo = 0, vs_lo = 0;
  int          lt_bad = 0, ft_bad = 0, fc_bad = 0;
  logic [15:0] fc_prev = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Move to the negedge just after the next counter update and tally monitors.
  task automatic adv();
    bit found = 1'b0;
    for (int i = 0; i < 2 * CD; i++) begin
      @(negedge clk);
      if (line_tick || frame_tick) stale++;
      if (pix_en) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) chk("pix_en_timeout", 32'd0, 32'd1);
    @(negedge clk);
    pc++;
    if (pix_en) stale++;
    if (line_tick !== (hCount == 10'd0)) lt_bad++;
    if (line_tick) lt_cnt++;
    if (frame_tick) begin
      ft_cnt++;
      if (!(hCount == 10'd0 && vCount == 10'd11)) ft_bad++;
    end
    if (frame_cnt !== fc_prev + (frame_tick ? 16'd1 : 16'd0)) fc_bad++;
    fc_prev = frame_cnt;
    if (bright) br_cnt++;
    if (!hSync) hs_lo++;
    if (!vSync) vs_lo++;
  endtask

  task automatic clear_mon();
    lt_cnt = 0; ft_cnt = 0; br_cnt = 0; hs_lo = 0; vs_lo = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;

    tbl[0]  = '{3,   3,  0,  3'b000, 16'd0, 12'h000};
    tbl[1]  = '{4,   4,  0,  3'b100, 16'd0, 12'h000};
    tbl[2]  = '{24,  24, 0,  3'b100, 16'd0, 12'h000};
    tbl[3]  = '{25,  0,  1,  3'b000, 16'd0, 12'h000};
    tbl[4]  = '{50,  0,  2,  3'b010, 16'd0, 12'h000};
    tbl[5]  = '{131, 6,  5,  3'b110, 16'd0, 12'h000};
    tbl[6]  = '{132, 7,  5,  3'b111, 16'd0, 12'hFFF};
    tbl[7]  = '{134, 9,  5,  3'b111, 16'd0, 12'hFF0};
    tbl[8]  = '{140, 15, 5,  3'b111, 16'd0, 12'hF0F};
    tbl[9]  = '{147, 22, 5,  3'b111, 16'd0, 12'h000};
    tbl[10] = '{148, 23, 5,  3'b110, 16'd0, 12'h000};
    tbl[11] = '{272, 22, 10, 3'b111, 16'd0, 12'h000};
    tbl[12] = '{275, 0,  11, 3'b010, 16'd1, 12'h000};
    tbl[13] = '{324, 24, 12, 3'b110, 16'd1, 12'h000};
    tbl[14] = '{325, 0,  0,  3'b000, 16'd1, 12'h000};

    // Reset held for three clocks: every output at its reset value.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_outputs",
          {pix_en, hCount, vCount, hSync, vSync, bright, line_tick, frame_tick},
          32'd0);
      chk("reset_frame_cnt", frame_cnt, 32'd0);
`ifdef VGA_TEST_PATTERN_EN
      chk("reset_rgb_tp", rgb_tp, 32'd0);
`endif
    end
    rst = 1'b0;

    // Divider start-up after release.
    @(negedge clk); chk("pix_en_rel1", pix_en, 32'd0);
    @(negedge clk); chk("pix_en_rel2", pix_en, 32'd0);
    @(negedge clk); chk("pix_en_rel3", pix_en, 32'd1);
    chk("h_before_first_update", hCount, 32'd0);
    @(negedge clk);
    pc = 1;
    chk("h_first_update", hCount, 32'd1);
    chk("pix_en_one_clock", pix_en, 32'd0);

    // Raster position table.
    foreach (tbl[k]) begin
      while (pc < tbl[k].p) adv();
      chk($sformatf("tbl%0d_h", k), hCount, tbl[k].h);
      chk($sformatf("tbl%0d_v", k), vCount, tbl[k].v);
      chk($sformatf("tbl%0d_hs_vs_br", k), {hSync, vSync, bright}, {29'd0, tbl[k].flags});
      chk($sformatf("tbl%0d_frame_cnt", k), frame_cnt, {16'd0, tbl[k].fc});
`ifdef VGA_TEST_PATTERN_EN
      chk($sformatf("tbl%0d_rgb_tp", k), rgb_tp, {20'd0, tbl[k].rgb});
`endif
    end

    // One line, then the rest of two whole frames.
    clear_mon();
    repeat (25) adv();
    chk("line_h_wrap", hCount, 32'd0);
    chk("line_v_adv", vCount, 32'd1);
    chk("line_tick_once", lt_cnt, 32'd1);
    chk("hsync_low_line", hs_lo, 32'd4);
    repeat (625) adv();
    chk("frames_h", hCount, 32'd0);
    chk("frames_v", vCount, 32'd0);
    chk("line_tick_2frames", lt_cnt, 32'd26);
    chk("frame_tick_2frames", ft_cnt, 32'd2);
    chk("bright_2frames", br_cnt, 32'd192);
    chk("hsync_low_2frames", hs_lo, 32'd104);
    chk("vsync_low_2frames", vs_lo, 32'd100);
    chk("frame_cnt_after", frame_cnt, 32'd3);
    chk("frame_tick_position", ft_bad, 32'd0);
    chk("frame_cnt_step", fc_bad, 32'd0);
    chk("line_tick_align", lt_bad, 32'd0);
    chk("tick_without_update", stale, 32'd0);

    // Reset on the very clock that would wrap into the front porch.
    repeat (274) adv();
    chk("pre_reset_h", hCount, 32'd24);
    chk("pre_reset_v", vCount, 32'd10);
    n = 0;
    while (!pix_en && n < 2 * CD) begin
      @(negedge clk);
      n++;
    end
    chk("pre_reset_pix_en", pix_en, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_outputs",
        {pix_en, hCount, vCount, hSync, vSync, bright, line_tick, frame_tick},
        32'd0);
    chk("midreset_frame_cnt", frame_cnt, 32'd0);
`ifdef VGA_TEST_PATTERN_EN
    chk("midreset_rgb_tp", rgb_tp, 32'd0);
`endif
    rst = 1'b0;
    n = 0;
    while (hCount != 10'd1 && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk("post_reset_first_update_clocks", n, 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
